// File: rtl/ans_delay_meas_fifo.sv
// UART answer-delay recorder: counts ticks from TX stop-bit done to first RX byte into a FIFO.
// Optional timeout detection is enabled with `define ANS_DLY_TIMEOUT_EN.
module ans_delay_meas_fifo #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_DLY = 999,
    parameter int unsigned FILL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_SendFinished_i,
    input  logic              p_DataReceived_i,
    input  logic              p_tick_i,
    input  logic              n_rd_i,
    input  logic              n_clr_i,
`ifdef ANS_DLY_TIMEOUT_EN
    input  logic [CNT_W-1:0]  ans_delay_limit_i,
    output logic              p_timeout_o,
`endif
    output logic [CNT_W-1:0]  ans_delay_o,
    output logic              p_valid_o,
    output logic [FILL_W-1:0] fill_o,
    output logic              p_overflow_o
);

    localparam logic [CNT_W-1:0]  MaxDly   = CNT_W'(MAX_DLY);
    localparam logic [CNT_W-1:0]  Sentinel = '1;
    localparam logic [FILL_W-1:0] FillFull = FILL_W'(DEPTH);

    logic              flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  mem_q [DEPTH];
    logic [CNT_W-1:0]  mem_d [DEPTH];
    logic [CNT_W-1:0]  shifted [DEPTH];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic              cnt_inc, timeout_evt, push, pop, wr_en;
    logic [CNT_W-1:0]  push_val;
    logic [FILL_W-1:0] widx;

    // Measurement interval and counter
    always_comb begin
        cnt_inc     = p_tick_i && flag_q && (cnt_q != MaxDly);
        timeout_evt = 1'b0;
`ifdef ANS_DLY_TIMEOUT_EN
        timeout_evt = cnt_inc && !p_SendFinished_i && n_clr_i && !p_DataReceived_i &&
                      (ans_delay_limit_i != '0) && ((cnt_q + CNT_W'(1)) == ans_delay_limit_i);
`endif
        cnt_d = cnt_q;
        if (p_SendFinished_i || !n_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        flag_d = flag_q;
        if (p_SendFinished_i) begin
            flag_d = 1'b1;
        end else if (p_DataReceived_i || timeout_evt) begin
            flag_d = 1'b0;
        end
        push     = (p_DataReceived_i && flag_q) || timeout_evt;
        push_val = timeout_evt ? Sentinel : cnt_q;
    end

    // Shift-register FIFO; slots at and beyond fill_q are kept at zero so the head reads 0 when empty
    always_comb begin
        pop = !n_rd_i && (fill_q != '0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = mem_q[i+1];
        end
        shifted[DEPTH-1] = '0;
        mem_d  = mem_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        widx   = '0;
        if (!n_clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            fill_d = '0;
            ovf_d  = 1'b0;
        end else if (push && pop) begin
            mem_d = shifted;
            wr_en = 1'b1;
            widx  = fill_q - FILL_W'(1);
        end else if (push && (fill_q == FillFull)) begin
            mem_d = shifted;
            wr_en = 1'b1;
            widx  = FillFull - FILL_W'(1);
            ovf_d = 1'b1;
        end else if (push) begin
            wr_en  = 1'b1;
            widx   = fill_q;
            fill_d = fill_q + FILL_W'(1);
        end else if (pop) begin
            mem_d  = shifted;
            fill_d = fill_q - FILL_W'(1);
        end
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (FILL_W'(i) == widx) begin
                    mem_d[i] = push_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef ANS_DLY_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_evt;
        end
    end

    assign p_timeout_o = timeout_q;
`endif

    assign ans_delay_o  = mem_q[0];
    assign p_valid_o    = (fill_q != '0);
    assign fill_o       = fill_q;
    assign p_overflow_o = ovf_q;

endmodule

// File: tb/tb_ans_delay_meas_fifo.sv
// Scoreboard bench for ans_delay_meas_fifo: expected delays are queued per measurement and
// compared by a monitor whenever the bench pops the FIFO.
module tb_ans_delay_meas_fifo;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_DLY = 999;
    localparam int unsigned FILL_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              send, rx, tick, n_rd, n_clr;
    logic [CNT_W-1:0]  limit;
    logic              timeout;
    logic [CNT_W-1:0]  ans_delay;
    logic              valid;
    logic [FILL_W-1:0] fill;
    logic              ovf;

    int unsigned exp_q[$];
    bit          exp_ovf;
    bit          pend_push;
    int          checks = 0;
    int          errors = 0;
    int          timeout_cnt = 0;
    logic [CNT_W-1:0] sentinel = '1;

    always #5 clk = ~clk;

    ans_delay_meas_fifo #(
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH),
        .MAX_DLY(MAX_DLY),
        .FILL_W (FILL_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .p_SendFinished_i (send),
        .p_DataReceived_i (rx),
        .p_tick_i         (tick),
        .n_rd_i           (n_rd),
        .n_clr_i          (n_clr),
`ifdef ANS_DLY_TIMEOUT_EN
        .ans_delay_limit_i(limit),
        .p_timeout_o      (timeout),
`endif
        .ans_delay_o      (ans_delay),
        .p_valid_o        (valid),
        .fill_o           (fill),
        .p_overflow_o     (ovf)
    );

`ifndef ANS_DLY_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    function automatic void check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic int unsigned exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : 0;
    endfunction

    // Reference: a reply measured after n ticks records min(n, MAX_DLY); full FIFO drops oldest
    function automatic void exp_push(int unsigned v, bit popping);
        if (!popping && exp_q.size() == DEPTH) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b1;
        end
        exp_q.push_back(v);
    endfunction

    function automatic void exp_clear();
        exp_q.delete();
        exp_ovf = 1'b0;
    endfunction

    // Monitor: every pop strobe presented to the DUT is scored against the reference head
    always @(negedge clk) begin
        if (rst) begin
            if (timeout) timeout_cnt++;
            if (!n_rd && n_clr) begin
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected_valid", 1, 0);
                    end else begin
                        check("pop_head", ans_delay, exp_q.pop_front());
                    end
                end else begin
                    check("pop_empty_model_size", exp_q.size(), pend_push ? 1 : 0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic measure(int unsigned n, bit pop_too);
        send = 1'b1;
        cyc();
        send = 1'b0;
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
        rx   = 1'b1;
        n_rd = !pop_too;
        exp_push((n > MAX_DLY) ? MAX_DLY : n, pop_too);
        pend_push = 1'b1;
        cyc();
        rx        = 1'b0;
        n_rd      = 1'b1;
        pend_push = 1'b0;
    endtask

    task automatic pop1();
        n_rd = 1'b0;
        cyc();
        n_rd = 1'b1;
    endtask

    task automatic clear();
        n_clr = 1'b0;
        cyc();
        n_clr = 1'b1;
        exp_clear();
    endtask

    task automatic check_state(string name);
        check({name, "_fill"}, fill, exp_q.size());
        check({name, "_valid"}, valid, exp_q.size() != 0);
        check({name, "_head"}, ans_delay, exp_head());
        check({name, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        rst = 1'b0; send = 1'b0; rx = 1'b0; tick = 1'b0; n_rd = 1'b1; n_clr = 1'b1;
        limit = '0; pend_push = 1'b0; exp_clear();
        repeat (3) cyc();
        check_state("reset");
        rst = 1'b1;
        cyc();

        // Single measurement
        measure(37, 0);
        check("t1_head", ans_delay, 37);
        check_state("t1");
        pop1();
        check_state("t1_popped");

        // Only the first RX byte of a reply is measured
        measure(2, 0);
        repeat (4) begin
            rx = 1'b1; cyc(); rx = 1'b0; cyc();
        end
        check_state("t2");
        pop1();

        // Overflow drops oldest
        clear();
        for (int i = 1; i <= 5; i++) measure(10 * i, 0);
        check("t3_head", ans_delay, 20);
        check_state("t3");
        for (int i = 0; i < 4; i++) begin
            pop1();
            check_state("t3_pop");
        end

        // Saturation and pop on empty
        measure(1200, 0);
        check("t4_sat", ans_delay, MAX_DLY);
        pop1();
        pop1();
        check_state("t4_empty_pop");

        // Push and pop together on a full FIFO
        clear();
        for (int i = 1; i <= 4; i++) measure(10 * i, 0);
        measure(55, 1);
        check("t5_head", ans_delay, 20);
        check_state("t5");
        clear();
        check_state("t5_clr");

        // Reset mid-measurement discards the interval
        send = 1'b1; cyc(); send = 1'b0;
        tick = 1'b1; repeat (20) cyc(); tick = 1'b0;
        rst = 1'b0; cyc(); rst = 1'b1; cyc();
        exp_clear();
        rx = 1'b1; cyc(); rx = 1'b0; cyc();
        check_state("rst_mid");

`ifdef ANS_DLY_TIMEOUT_EN
        limit = CNT_W'(100);
        send = 1'b1; cyc(); send = 1'b0;
        tick = 1'b1;
        repeat (99) cyc();
        check("to_early", timeout, 0);
        cyc();
        check("to_pulse", timeout, 1);
        exp_push(sentinel, 0);
        cyc();
        tick = 1'b0;
        check("to_one_cycle", timeout, 0);
        rx = 1'b1; cyc(); rx = 1'b0; cyc();
        check_state("to_after_rx");
        limit = '0;
        timeout_cnt = 0;
        measure(150, 0);
        check("to_disabled_cnt", timeout_cnt, 0);
        check_state("to_disabled");
        clear();
`endif

        // Randomized measurements, spurious RX/ticks and pops
        for (int it = 0; it < 40; it++) begin
            measure($urandom_range(0, 80), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rx = 1'b1; cyc(); rx = 1'b0;
            end
            repeat ($urandom_range(0, 3)) begin
                tick = $urandom_range(0, 1) == 1;
                cyc();
            end
            tick = 1'b0;
            repeat ($urandom_range(0, 2)) pop1();
            check_state("rand");
        end
        while (exp_q.size() != 0 && valid) pop1();
        check_state("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
